// File: rtl/psum_accumulator_if.sv
// -----------------------------------------------------------------------------
// psum_accumulator_if
// Bundles the signals between the partial-sum accumulator and its neighbours.
//   Input side (controller / adder tree -> accumulator):
//     in_valid, in_last : beat sideband, issued with the tree input vector
//     in_ready          : a group-closing beat may be issued
//     sum               : signed adder tree result
//     shift             : arithmetic right-shift amount for result formation
//   Output side (accumulator -> downstream):
//     out_valid, out_ready : result handshake
//     out_data, out_sat    : rounded/saturated result and its clip flag
// Modports: master drives the beats and accepts results; slave is the
// accumulator.
// -----------------------------------------------------------------------------
interface psum_accumulator_if #(
  parameter int IN_W  = 21,
  parameter int OUT_W = 16,
  parameter int SH_W  = 5
);
  logic                    in_valid;
  logic                    in_last;
  logic                    in_ready;
  logic signed [IN_W-1:0]  sum;
  logic [SH_W-1:0]         shift;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_sat;

  modport master (
    output in_valid, in_last, sum, shift, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_last, sum, shift, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/psum_accumulator.sv
// -----------------------------------------------------------------------------
// psum_accumulator
// Consumer end of the PE adder tree. The valid/last sideband issued with each
// tree input vector is delayed by the tree latency so it lines up with `sum`.
// Partial sums of one group are accumulated; on the last beat the total is
// rounded (half up), arithmetically shifted and saturated to OUT_W, then
// pushed into a 2-entry output buffer. in_ready gives credit-based
// back-pressure on group-closing beats.
// Ports:
//   clk     : clock
//   rst     : synchronous active-high reset
//   clk_en  : pipeline advance enable shared with the adder tree
//   bus     : psum_accumulator_if.slave (input beats, shift, output results)
//   err_ovf : sticky protocol error (last beat without credit, or buffer drop)
// -----------------------------------------------------------------------------
module psum_accumulator #(
  parameter int DATA_W   = 16,
  parameter int DATA_N   = 32,
  parameter int IN_W     = $clog2(DATA_N) + DATA_W,
  parameter int TREE_LAT = $clog2(DATA_N) + 1,
  parameter int ACC_W    = 32,
  parameter int OUT_W    = 16,
  parameter int SH_W     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  psum_accumulator_if.slave bus,
  output logic              err_ovf
);

  localparam int PEND_W = $clog2(TREE_LAT + 3);
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = -SAT_MAX - 1;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             sat;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Sideband delay line. dl_last holds valid&last so the credit count can
  // popcount it directly.
  // ---------------------------------------------------------------------------
  logic [TREE_LAT-1:0] dl_valid, dl_last, dl_valid_nxt, dl_last_nxt;
  logic                d_valid, d_last;

  always_comb begin
    dl_valid_nxt = dl_valid;
    dl_last_nxt  = dl_last;
    if (clk_en) begin
      dl_valid_nxt = {dl_valid[TREE_LAT-2:0], bus.in_valid};
      dl_last_nxt  = {dl_last[TREE_LAT-2:0], bus.in_valid & bus.in_last};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (rst) begin
      dl_valid <= '0;
      dl_last  <= '0;
    end else begin
      dl_valid <= dl_valid_nxt;
      dl_last  <= dl_last_nxt;
    end
  end

  assign d_valid = dl_valid[TREE_LAT-1];
  assign d_last  = dl_last[TREE_LAT-1];

  // ---------------------------------------------------------------------------
  // Accumulator
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0] acc, operand, nxt;
  logic                    first;
  logic                    acc_en, push;

  assign acc_en  = clk_en & d_valid;
  assign push    = acc_en & d_last;
  assign operand = {{(ACC_W-IN_W){bus.sum[IN_W-1]}}, bus.sum};
  // `first` replaces the old total with zero so a new group needs no clear beat.
  assign nxt     = (first ? '0 : acc) + operand;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      first <= 1'b1;
    end else if (acc_en) begin
      if (d_last) begin
        acc   <= '0;
        first <= 1'b1;
      end else begin
        acc   <= nxt;
        first <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result formation: round half up, arithmetic shift, saturate. One extra bit
  // keeps the rounding add from wrapping near the top of the ACC_W range.
  // ---------------------------------------------------------------------------
  logic signed [ACC_W:0]   nxt_ext, rnd_inc, rnd_sum, shifted;
  logic        [OUT_W-1:0] res_data;
  logic                    res_sat;

  // NOTE: every combinational output gets a default first so no path through
  // the block leaves a signal unassigned and infers a latch.
  always_comb begin
    nxt_ext  = {nxt[ACC_W-1], nxt};
    rnd_inc  = (ACC_W+1)'(1) << (bus.shift - 1'b1);
    rnd_sum  = nxt_ext + rnd_inc;
    shifted  = (bus.shift == '0) ? nxt_ext : (rnd_sum >>> bus.shift);
    res_data = shifted[OUT_W-1:0];
    res_sat  = 1'b0;
    if (shifted > SAT_MAX) begin
      res_data = SAT_MAX[OUT_W-1:0];
      res_sat  = 1'b1;
    end else if (shifted < SAT_MIN) begin
      res_data = SAT_MIN[OUT_W-1:0];
      res_sat  = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // 2-entry output buffer. When empty the head pointer is stepped back one
  // slot so out_data/out_sat keep showing the last popped entry.
  // ---------------------------------------------------------------------------
  entry_t     mem [2];
  logic       wr_ptr, rd_ptr, head_sel;
  logic [1:0] count, count_nxt;
  logic       pop, full, wr_en, drop;

  assign pop   = (count != 2'd0) & bus.out_ready;
  assign full  = (count == 2'd2);
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_comb begin
    count_nxt = count;
    if (wr_en && !pop)      count_nxt = count + 2'd1;
    else if (!wr_en && pop) count_nxt = count - 2'd1;
  end

  // NOTE: the buffer storage is reset because its contents are visible on
  // out_data/out_sat while empty, and those must read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= '{data: res_data, sat: res_sat};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count_nxt;
    end
  end

  assign head_sel      = (count == 2'd0) ? ~rd_ptr : rd_ptr;
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_data  = mem[head_sel].data;
  assign bus.out_sat   = mem[head_sel].sat;

  // ---------------------------------------------------------------------------
  // Credit and protocol error. Pending counts results that will occupy the
  // buffer: those already in it plus last beats still in the delay line, all
  // evaluated after this cycle's push, pop and shift.
  // ---------------------------------------------------------------------------
  logic [PEND_W-1:0] pending;
  logic              in_ready_q;

  always_comb begin
    pending = PEND_W'(count_nxt);
    for (int i = 0; i < TREE_LAT; i++) begin
      pending = pending + PEND_W'(dl_last_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q <= 1'b1;
      err_ovf    <= 1'b0;
    end else begin
      in_ready_q <= (pending < PEND_W'(2));
      if ((clk_en & bus.in_valid & bus.in_last & ~in_ready_q) | drop) begin
        err_ovf <= 1'b1;
      end
    end
  end

  assign bus.in_ready = in_ready_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// -----------------------------------------------------------------------------
// tb_psum_accumulator
// Drives beats through a behavioural adder-tree delay (TREE_LAT clk_en
// stages) into psum_accumulator. Expected results are queued when a group is
// issued and compared by a monitor when the DUT hands a result downstream.
// -----------------------------------------------------------------------------
module tb_psum_accumulator;

  localparam int IN_W     = 21;
  localparam int OUT_W    = 16;
  localparam int SH_W     = 5;
  localparam int TREE_LAT = 6;

  typedef struct {
    logic signed [OUT_W-1:0] data;
    logic                    sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic clk_en;
  logic err_ovf;

  psum_accumulator_if #(.IN_W(IN_W), .OUT_W(OUT_W), .SH_W(SH_W)) bus ();

  psum_accumulator #(
    .DATA_W(16), .DATA_N(32), .IN_W(IN_W), .TREE_LAT(TREE_LAT),
    .ACC_W(32), .OUT_W(OUT_W), .SH_W(SH_W)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .bus    (bus),
    .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  // Behavioural adder tree: the vector's sum appears TREE_LAT enabled cycles
  // after it is sampled.
  logic signed [IN_W-1:0] vec_sum;
  logic signed [IN_W-1:0] tree_pipe [TREE_LAT];

  always @(posedge clk) begin
    if (clk_en) begin
      tree_pipe[0] <= bus.in_valid ? vec_sum : '0;
      for (int i = 1; i < TREE_LAT; i++) tree_pipe[i] <= tree_pipe[i-1];
    end
  end
  assign bus.sum = tree_pipe[TREE_LAT-1];

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  // Scoreboard monitor: every accepted result must match the oldest expected.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: got data=%0d sat=%0b, required no output",
                 bus.out_data, bus.out_sat);
      end else begin
        e = sb.pop_front();
        if (bus.out_data !== e.data || bus.out_sat !== e.sat) begin
          n_err++;
          $display("FAIL result: got data=%0d sat=%0b, required data=%0d sat=%0b",
                   bus.out_data, bus.out_sat, e.data, e.sat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required self-termination");
    $fatal(1);
  end

  task automatic expect_res(input int d, input logic s);
    exp_t e;
    e.data = OUT_W'(d);
    e.sat  = s;
    sb.push_back(e);
  endtask

  // One enabled beat; returns #1 after the edge that sampled it.
  task automatic send(input int s, input logic last);
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    vec_sum      = IN_W'(s);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: got %0d results outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clk_en = 1'b1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    bus.shift = '0; vec_sum = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %0b, required 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 16'sd0) begin n_err++; $display("FAIL rst_out_data: got %0d, required 0", bus.out_data); end
    n_cmp++; if (bus.out_sat !== 1'b0) begin n_err++; $display("FAIL rst_out_sat: got %0b, required 0", bus.out_sat); end
    n_cmp++; if (err_ovf !== 1'b0) begin n_err++; $display("FAIL rst_err_ovf: got %0b, required 0", err_ovf); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %0b, required 1", bus.in_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL idle_in_ready: got %0b, required 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    int lat;
    logic seen;
    bus.shift = '0;
    expect_res(75, 1'b0);
    send(100, 1'b0);
    send(-30, 1'b0);
    send(5, 1'b1);
    lat = 1; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.out_valid) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    n_cmp++;
    if (!seen || lat != TREE_LAT + 1) begin
      n_err++;
      $display("FAIL basic_latency: got %0d cycles (seen=%0b), required %0d", lat, seen, TREE_LAT + 1);
    end
    wait_drain("basic");
  endtask

  task automatic test_round();
    bus.shift = SH_W'(2);
    expect_res(3, 1'b0);  send(10, 1'b1);
    expect_res(-2, 1'b0); send(-10, 1'b1);
    wait_drain("round_sh2");
    bus.shift = SH_W'(1);
    expect_res(3, 1'b0);  send(5, 1'b1);
    expect_res(-2, 1'b0); send(-5, 1'b1);
    wait_drain("round_sh1");
    bus.shift = '0;
  endtask

  task automatic test_saturation();
    bus.shift = '0;
    expect_res(32767, 1'b1);
    for (int i = 0; i < 4; i++) send(20000, i == 3);
    expect_res(-32768, 1'b1);
    for (int i = 0; i < 4; i++) send(-20000, i == 3);
    wait_drain("saturation");
  endtask

  task automatic test_back_to_back();
    expect_res(7, 1'b0);
    expect_res(-1, 1'b0);
    send(3, 1'b0);
    send(4, 1'b1);
    send(-1, 1'b1);
    wait_drain("back_to_back");
  endtask

  task automatic test_clk_en();
    int   sent, lat;
    logic seen;
    expect_res(4, 1'b0);
    sent = 0; lat = 0; seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      clk_en = (c % 2 == 0);
      if (clk_en && sent < 4) begin
        bus.in_valid = 1'b1; bus.in_last = (sent == 3); vec_sum = 1; sent++;
      end else begin
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
      end
      @(posedge clk); #1;
      if (clk_en && sent == 4) lat++;
      if (bus.out_valid) seen = 1'b1;
    end
    clk_en = 1'b1; bus.in_valid = 1'b0; bus.in_last = 1'b0;
    n_cmp++;
    if (!seen || lat != TREE_LAT + 1) begin
      n_err++;
      $display("FAIL clk_en_latency: got %0d enabled cycles (seen=%0b), required %0d", lat, seen, TREE_LAT + 1);
    end
    wait_drain("clk_en");
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    expect_res(111, 1'b0);
    send(111, 1'b1);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_after_1: got %0b, required 1", bus.in_ready); end
    expect_res(222, 1'b0);
    send(222, 1'b1);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_after_2: got %0b, required 0", bus.in_ready); end
    n_cmp++; if (err_ovf !== 1'b0) begin n_err++; $display("FAIL bp_err_before_3: got %0b, required 0", err_ovf); end
    send(333, 1'b1);
    n_cmp++; if (err_ovf !== 1'b1) begin n_err++; $display("FAIL bp_err_after_3: got %0b, required 1", err_ovf); end
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_held_valid: got %0b, required 1", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 16'sd111) begin n_err++; $display("FAIL bp_held_head: got %0d, required 111", bus.out_data); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready: got %0b, required 0", bus.in_ready); end
    bus.out_ready = 1'b1;
    wait_drain("backpressure");
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_third_dropped: got out_valid=%0b, required 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 16'sd222) begin n_err++; $display("FAIL bp_empty_hold: got %0d, required 222", bus.out_data); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_restored: got %0b, required 1", bus.in_ready); end
    n_cmp++; if (err_ovf !== 1'b1) begin n_err++; $display("FAIL bp_err_sticky: got %0b, required 1", err_ovf); end
  endtask

  task automatic test_mid_reset();
    send(50, 1'b0);
    send(60, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (err_ovf !== 1'b0) begin n_err++; $display("FAIL mid_rst_err_clear: got %0b, required 0", err_ovf); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_in_ready: got %0b, required 1", bus.in_ready); end
    expect_res(7, 1'b0);
    send(7, 1'b1);
    wait_drain("mid_reset");
    repeat (12) @(posedge clk);
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_no_stale: got out_valid=%0b, required 0", bus.out_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round();
    test_saturation();
    test_back_to_back();
    test_clk_en();
    test_backpressure();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
